// File: rtl/ldpc_pkg.sv
// Shared constants and state encoding for the LDPC encoder front-end blocks.
// Covers the CCSDS (8160,7136) code geometry and the frame arbiter FSM.
package ldpc_pkg;

  localparam int K_8160_7136 = 7136;
  localparam int N_8160_7136 = 8160;

  // Wide enough to hold K-1 for the (8160,7136) code
  localparam int BIT_CNT_W = 13;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ARB   = 4'b0010,
    ST_FEED  = 4'b0100,
    ST_DRAIN = 4'b1000
  } arb_state_e;

endpackage

// File: rtl/ldpc_rr_pick.sv
// Combinational round-robin priority encoder: the first requester at or after
// ptr (wrapping modulo N_CH) wins.
module ldpc_rr_pick
  import ldpc_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] grant_idx,
  output logic            any
);

  logic [CH_W-1:0] cand_s;

  // Walk offsets from farthest to nearest so the nearest requester is written last
  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    cand_s    = '0;
    for (int off = N_CH - 1; off >= 0; off--) begin
      cand_s    = CH_W'((int'(ptr) + off) % N_CH);
      grant_idx = req[cand_s] ? cand_s : grant_idx;
      any       = any | req[cand_s];
    end
  end

endmodule

// File: rtl/ldpc_enc_frame_arbiter.sv
// Shares one serial LDPC encoder among N_CH bit-serial sources, granting it for
// one whole frame and holding the grant until the codeword has drained.
module ldpc_enc_frame_arbiter
  import ldpc_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH),
  parameter int K    = K_8160_7136
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] s_axis_tdata,
  input  logic [N_CH-1:0] s_axis_tvalid,
  output logic [N_CH-1:0] s_axis_tready,
  output logic            enc_s_axis_tdata,
  output logic            enc_s_axis_tvalid,
  input  logic            enc_s_axis_tready,
  input  logic            enc_m_axis_tdata,
  input  logic            enc_m_axis_tvalid,
  input  logic            enc_m_axis_tlast,
  output logic            enc_m_axis_tready,
  output logic            m_axis_tdata,
  output logic            m_axis_tvalid,
  output logic            m_axis_tlast,
  output logic [CH_W-1:0] m_axis_tuser,
  input  logic            m_axis_tready,
  output logic            busy,
  output logic [15:0]     frame_done_cnt
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(K - 1);
  localparam logic [CH_W-1:0]      LAST_CH  = CH_W'(N_CH - 1);

  arb_state_e           state_q, state_d;
  logic [CH_W-1:0]      cur_ch_q, cur_ch_d;
  logic [CH_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [15:0]          frame_done_cnt_q, frame_done_cnt_d;

  logic [CH_W-1:0]      pick_idx_s;
  logic                 pick_any_s;
  logic                 sel_valid_s;
  logic                 sel_data_s;
  logic                 feed_hs_s;
  logic                 cw_done_s;

  ldpc_rr_pick #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_rr_pick (
    .req       (s_axis_tvalid),
    .ptr       (rr_ptr_q),
    .grant_idx (pick_idx_s),
    .any       (pick_any_s)
  );

  assign sel_valid_s = s_axis_tvalid[cur_ch_q];
  assign sel_data_s  = s_axis_tdata[cur_ch_q];
  assign feed_hs_s   = sel_valid_s & enc_s_axis_tready;
  assign cw_done_s   = enc_m_axis_tvalid & enc_m_axis_tlast & m_axis_tready;

  // The encoder never overlaps codewords, so the output side is a straight wire
  assign m_axis_tdata      = enc_m_axis_tdata;
  assign m_axis_tvalid     = enc_m_axis_tvalid;
  assign m_axis_tlast      = enc_m_axis_tlast;
  assign enc_m_axis_tready = m_axis_tready;
  assign m_axis_tuser      = cur_ch_q;
  assign busy              = (state_q != ST_IDLE);
  assign frame_done_cnt    = frame_done_cnt_q;

  // Next-state logic, frame counters and input-side steering
  always_comb begin
    state_d           = state_q;
    cur_ch_d          = cur_ch_q;
    rr_ptr_d          = rr_ptr_q;
    bit_cnt_d         = bit_cnt_q;
    frame_done_cnt_d  = frame_done_cnt_q;
    s_axis_tready     = '0;
    enc_s_axis_tdata  = 1'b0;
    enc_s_axis_tvalid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|s_axis_tvalid) begin
          state_d = ST_ARB;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ARB: begin
        if (pick_any_s) begin
          cur_ch_d  = pick_idx_s;
          bit_cnt_d = '0;
          state_d   = ST_FEED;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FEED: begin
        s_axis_tready[cur_ch_q] = enc_s_axis_tready;
        enc_s_axis_tdata        = sel_data_s;
        enc_s_axis_tvalid       = sel_valid_s;
        // A stalled source freezes the count; the grant is never revoked
        if (feed_hs_s) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = ST_DRAIN;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end

      ST_DRAIN: begin
        if (cw_done_s) begin
          frame_done_cnt_d = frame_done_cnt_q + 16'd1;
          rr_ptr_d         = (cur_ch_q == LAST_CH) ? '0 : cur_ch_q + CH_W'(1);
          state_d          = (|s_axis_tvalid) ? ST_ARB : ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      cur_ch_q         <= '0;
      rr_ptr_q         <= '0;
      bit_cnt_q        <= '0;
      frame_done_cnt_q <= 16'd0;
    end else begin
      state_q          <= state_d;
      cur_ch_q         <= cur_ch_d;
      rr_ptr_q         <= rr_ptr_d;
      bit_cnt_q        <= bit_cnt_d;
      frame_done_cnt_q <= frame_done_cnt_d;
    end
  end

endmodule

// File: tb/tb_ldpc_enc_frame_arbiter.sv
// Directed bench for ldpc_enc_frame_arbiter; the bench plays the sources, a
// stand-in encoder (K bits in, out_len bits out) and the downstream sink.
module tb_ldpc_enc_frame_arbiter;
  import ldpc_pkg::*;

  localparam int N_CH = 4;
  localparam int CH_W = 2;
  localparam int K    = K_8160_7136;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N_CH-1:0] s_axis_tdata, s_axis_tvalid, s_axis_tready;
  logic            enc_s_axis_tdata, enc_s_axis_tvalid, enc_s_axis_tready;
  logic            enc_m_axis_tdata, enc_m_axis_tvalid, enc_m_axis_tlast, enc_m_axis_tready;
  logic            m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [CH_W-1:0] m_axis_tuser;
  logic            busy;
  logic [15:0]     frame_done_cnt;

  always #5 clk = ~clk;

  ldpc_enc_frame_arbiter #(.N_CH(N_CH), .CH_W(CH_W), .K(K)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .enc_s_axis_tdata(enc_s_axis_tdata), .enc_s_axis_tvalid(enc_s_axis_tvalid),
    .enc_s_axis_tready(enc_s_axis_tready),
    .enc_m_axis_tdata(enc_m_axis_tdata), .enc_m_axis_tvalid(enc_m_axis_tvalid),
    .enc_m_axis_tlast(enc_m_axis_tlast), .enc_m_axis_tready(enc_m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
    .busy(busy), .frame_done_cnt(frame_done_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  // Bench-side model state
  logic [N_CH-1:0] src_en;
  int   src_sent [N_CH];
  int   enc_rdy_low, rdy_low, out_len;
  int   stub_in, stub_out, out_seen, fed_ch;
  logic stub_out_phase, stub_par, last_par;
  int   tuser_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic src_bit(input int ch, input int idx);
    return 1'((idx ^ (idx >>> 3) ^ ch) & 1);
  endfunction

  function automatic logic golden_par(input int ch);
    logic p;
    p = 1'b0;
    for (int i = 0; i < K; i++) p = p ^ src_bit(ch, i);
    return p;
  endfunction

  // Drive one cycle of inputs at the falling edge, then check the combinational response
  task automatic drive();
    for (int c = 0; c < N_CH; c++) begin
      s_axis_tvalid[c] = src_en[c];
      s_axis_tdata[c]  = src_bit(c, src_sent[c]);
    end
    enc_s_axis_tready = ($urandom_range(99) >= enc_rdy_low);
    m_axis_tready     = ($urandom_range(99) >= rdy_low);
    enc_m_axis_tvalid = stub_out_phase;
    enc_m_axis_tdata  = stub_par ^ 1'(stub_out & 1);
    enc_m_axis_tlast  = stub_out_phase && (stub_out == out_len - 1);
    #1;
    chk("rdy_onehot0", 32'($onehot0(s_axis_tready)), 32'd1);
    chk("m_tdata", 32'(m_axis_tdata), 32'(enc_m_axis_tdata));
    chk("m_tvalid", 32'(m_axis_tvalid), 32'(enc_m_axis_tvalid));
    chk("m_tlast", 32'(m_axis_tlast), 32'(enc_m_axis_tlast));
    chk("enc_m_tready", 32'(enc_m_axis_tready), 32'(m_axis_tready));
    chk("hs_pair", 32'(|(s_axis_tvalid & s_axis_tready)), 32'(enc_s_axis_tvalid & enc_s_axis_tready));
    if (stub_out_phase) chk("drain_quiet", {27'd0, s_axis_tready, enc_s_axis_tvalid}, 32'd0);
    for (int c = 0; c < N_CH; c++) begin
      if (s_axis_tready[c]) begin
        chk("rdy_follow", 32'(enc_s_axis_tready), 32'd1);
        chk("mux_valid", 32'(enc_s_axis_tvalid), 32'(s_axis_tvalid[c]));
        if (s_axis_tvalid[c]) chk("mux_data", 32'(enc_s_axis_tdata), 32'(s_axis_tdata[c]));
      end
    end
  endtask

  // Commit the handshakes of this cycle at the rising edge and advance the models
  task automatic adv();
    logic [N_CH-1:0] acc_v;
    logic enc_hs, out_hs, din, tlast_cap;
    int acc_ch, tuser_cap;
    acc_v     = s_axis_tvalid & s_axis_tready;
    enc_hs    = enc_s_axis_tvalid & enc_s_axis_tready;
    out_hs    = m_axis_tvalid & m_axis_tready;
    din       = enc_s_axis_tdata;
    tlast_cap = m_axis_tlast;
    tuser_cap = int'(m_axis_tuser);
    acc_ch    = -1;
    for (int c = 0; c < N_CH; c++) if (acc_v[c]) acc_ch = c;
    @(posedge clk);
    for (int c = 0; c < N_CH; c++) if (acc_v[c]) src_sent[c]++;
    if (enc_hs) begin
      if (stub_in == 0) fed_ch = acc_ch;
      else chk("owner", acc_ch, fed_ch);
      stub_par = stub_par ^ din;
      stub_in++;
      if (stub_in == K) begin
        stub_out_phase = 1'b1;
        stub_out = 0;
        out_seen = 0;
        last_par = stub_par;
      end
    end
    if (out_hs) begin
      out_seen++;
      if (tlast_cap) begin
        chk("cw_len", out_seen, out_len);
        chk("tuser_at_tlast", tuser_cap, fed_ch);
        tuser_log.push_back(tuser_cap);
        stub_out_phase = 1'b0;
        stub_in = 0;
        stub_par = 1'b0;
      end else begin
        stub_out++;
      end
    end
    @(negedge clk);
  endtask

  task automatic run_until_frames(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && tuser_log.size() < n; i++) begin
      drive();
      adv();
    end
    chk(tag, tuser_log.size(), n);
  endtask

  task automatic run_until_sent(input string tag, input int ch, input int n, input int budget);
    for (int i = 0; i < budget && src_sent[ch] < n; i++) begin
      drive();
      adv();
    end
    chk(tag, src_sent[ch], n);
  endtask

  // Assert reset with the inputs still live, check the async response, then restart everyone
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_rdy"}, 32'(s_axis_tready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_enc_valid"}, 32'(enc_s_axis_tvalid), 32'd0);
    chk({tag, "_fdc"}, 32'(frame_done_cnt), 32'd0);
    chk({tag, "_tuser"}, 32'(m_axis_tuser), 32'd0);
    src_en = '0;
    s_axis_tvalid = '0;
    s_axis_tdata = '0;
    enc_s_axis_tready = 1'b0;
    enc_m_axis_tdata = 1'b0;
    enc_m_axis_tvalid = 1'b0;
    enc_m_axis_tlast = 1'b0;
    m_axis_tready = 1'b0;
    for (int c = 0; c < N_CH; c++) src_sent[c] = 0;
    stub_in = 0; stub_out = 0; out_seen = 0; fed_ch = -1;
    stub_out_phase = 1'b0; stub_par = 1'b0; last_par = 1'b0;
    enc_rdy_low = 0; rdy_low = 0; out_len = 4;
    tuser_log.delete();
    #1;
    chk({tag, "_m_valid"}, 32'(m_axis_tvalid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    src_en = '0;
    for (int c = 0; c < N_CH; c++) src_sent[c] = 0;
    stub_in = 0; stub_out = 0; out_seen = 0; fed_ch = -1;
    stub_out_phase = 1'b0; stub_par = 1'b0; last_par = 1'b0;
    enc_rdy_low = 0; rdy_low = 0; out_len = 4;
    #2;
    do_reset("por");

    // 1: ch0 alone, full-length codeword, IDLE -> ARB -> FEED timing
    out_len = N_8160_7136;
    src_en = 4'b0001;
    drive();
    chk("t1_idle_rdy", 32'(s_axis_tready), 32'd0);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    adv();
    drive();
    chk("t1_arb_busy", 32'(busy), 32'd1);
    chk("t1_arb_rdy", 32'(s_axis_tready), 32'd0);
    adv();
    drive();
    chk("t1_feed_rdy", 32'(s_axis_tready), 32'h1);
    chk("t1_tuser", 32'(m_axis_tuser), 32'd0);
    adv();
    run_until_frames("t1_frames", 1, 16000);
    chk("t1_cw_tuser", tuser_log[0], 0);
    chk("t1_parity", 32'(last_par), 32'(golden_par(0)));
    chk("t1_fdc", 32'(frame_done_cnt), 32'd1);
    do_reset("t1_rst");

    // 2: all channels from reset -> rr order 0,1,2,3 then 0 again
    src_en = 4'b1111;
    run_until_frames("t2_frames", 4, 4 * (K + 16));
    for (int i = 0; i < 4 && i < tuser_log.size(); i++) chk("t2_order", tuser_log[i], i);
    chk("t2_fdc", 32'(frame_done_cnt), 32'd4);
    for (int i = 0; i < 8 && stub_in == 0; i++) begin
      drive();
      adv();
    end
    chk("t2_fifth_grant", fed_ch, 0);
    do_reset("t2_rst");

    // 3/4: ch2 stalls 50 cycles at bit 3000, with encoder and sink backpressure
    src_en = 4'b0100;
    out_len = 32;
    rdy_low = 30;
    enc_rdy_low = 20;
    run_until_sent("t3_reach_3000", 2, 3000, 6000);
    src_en = 4'b0000;
    for (int i = 0; i < 50; i++) begin
      drive();
      chk("t3_hold_rdy", 32'(s_axis_tready), {28'd0, 1'b0, enc_s_axis_tready, 2'b00});
      chk("t3_no_fwd", 32'(enc_s_axis_tvalid), 32'd0);
      adv();
    end
    src_en = 4'b0100;
    run_until_frames("t3_frames", 1, 12000);
    chk("t3_cw_tuser", tuser_log[0], 2);
    chk("t3_parity", 32'(last_par), 32'(golden_par(2)));
    chk("t3_fdc", 32'(frame_done_cnt), 32'd1);
    do_reset("t3_rst");

    // 5: reset in the middle of FEED, then ch0 wins again over ch3
    src_en = 4'b0001;
    run_until_sent("t5_reach_4000", 0, 4000, 5000);
    do_reset("t5_midrst");
    src_en = 4'b1001;
    run_until_frames("t5_frames", 1, K + 64);
    chk("t5_cw_tuser", tuser_log[0], 0);
    chk("t5_parity", 32'(last_par), 32'(golden_par(0)));
    chk("t5_fdc", 32'(frame_done_cnt), 32'd1);
    do_reset("t5_rst");

    // 6: ch1 frame; ch0 and ch3 rise on ch1's tlast -> ch3 after one ARB cycle
    src_en = 4'b0010;
    for (int i = 0; i < K + 64 && !stub_out_phase; i++) begin
      drive();
      adv();
    end
    chk("t6_in_drain", 32'(stub_out_phase), 32'd1);
    src_en = 4'b0000;
    for (int i = 0; i < 20 && tuser_log.size() == 0; i++) begin
      if (stub_out_phase && stub_out == out_len - 1) src_en = 4'b1001;
      drive();
      adv();
    end
    chk("t6_frames", tuser_log.size(), 1);
    chk("t6_fdc", 32'(frame_done_cnt), 32'd1);
    drive();
    chk("t6_arb_rdy", 32'(s_axis_tready), 32'd0);
    chk("t6_arb_busy", 32'(busy), 32'd1);
    adv();
    drive();
    chk("t6_grant_ch3", 32'(s_axis_tready), 32'h8);
    chk("t6_tuser", 32'(m_axis_tuser), 32'd3);
    adv();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
